// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizes for the MAR/MDR memory responder.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/sync_ram.sv
// Single-port RAM with synchronous write and registered read (read-first).
module sync_ram #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32,
    parameter string       INIT_FILE = ""
) (
    input  logic              i_clock,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory half of the MAR/MDR protocol: edge-detected Read/Write strobes, fixed wait
// states, then a one-cycle mem_ready with read data registered onto Mdatain.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       MARaddr,
    input  logic [DATA_W-1:0] MDRdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    state_e             r_state;
    op_e                r_op;
    logic               r_req_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_mdatain;
    logic               r_ready;
    logic               r_err;

    logic               w_req;
    logic               w_req_edge;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic               w_ram_we;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_unused_addr;

    assign w_req      = Read | Write;
    assign w_req_edge = w_req & ~r_req_q;

    // Present the live address while idle so the read word is already registered
    // by the time DONE is reached, even with zero wait states.
    assign w_ram_addr = (r_state == IDLE) ? MARaddr[ADDR_W-1:0] : r_addr;
    assign w_ram_we   = (r_state == DONE) && (r_op == OP_WR) && !clear;

    // Upper MAR bits alias onto the RAM.
    assign w_unused_addr = ^MARaddr[31:ADDR_W];

    sync_ram #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_FILE(INIT_FILE)
    ) u_ram (
        .i_clock(clock),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(r_wdata),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= IDLE;
            r_op      <= OP_RD;
            r_req_q   <= 1'b0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mdatain <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_req_q <= w_req;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req_edge) begin
                        if (Read && Write) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr  <= MARaddr[ADDR_W-1:0];
                            r_wdata <= MDRdata;
                            r_op    <= Write ? OP_WR : OP_RD;
                            r_cnt   <= WAIT_CYCLES[CNT_W-1:0];
                            r_state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (r_op == OP_RD) begin
                        r_mdatain <= w_rdata;
                    end
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Mdatain   = r_mdatain;
    assign mem_ready = r_ready;
    assign mem_busy  = (r_state == WAIT) || (r_state == DONE);
    assign mem_err   = r_err;

endmodule
